// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
package arith_pkg;

  // Default operand width shared with the adder blocks.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell; counterpart of the ripple full-adder cell.
module full_subtractor
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Difference bit and borrow out of a - b - bin.
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor stage, LSB first, registered borrow.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_sh_nxt;
  logic             brw;
  logic [CNT_W-1:0] cnt;

  logic             bit_d;
  logic             bit_nb;
  logic             last_c;

  // Active bit position always sits at index 0 of the operand shifters.
  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .diff (bit_d),
    .bout (bit_nb)
  );

  // New difference bit enters at the MSB; a one-bit result is just the bit.
  if (WIDTH == 1) begin : g_dsh_w1
    assign d_sh_nxt = bit_d;
  end else begin : g_dsh_wn
    assign d_sh_nxt = {bit_d, d_sh[WIDTH-1:1]};
  end

  assign last_c = (cnt == CNT_W'(WIDTH - 1));

  // Next-state and status decode; busy/done follow the state being entered.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)  state_nxt = ST_RUN;
      ST_RUN:  if (last_c) state_nxt = ST_DONE;
      ST_DONE:             state_nxt = ST_IDLE;
      default:             state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

  // State register with registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Operand load, per-bit shift and result capture on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
            d_sh <= '0;
          end
        end
        ST_RUN: begin
          d_sh <= d_sh_nxt;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= bit_nb;
          cnt  <= cnt + CNT_W'(1);
          if (last_c) begin
            diff <= d_sh_nxt;
            bout <= bit_nb;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  logic       start1, bin1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int done_cnt8 = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completed-operation counter for the 8-bit instance.
  always @(negedge clk) if (done8) done_cnt8 <= done_cnt8 + 1;

  // Reference: plain unsigned arithmetic, borrow is the bit above the result.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - 9'(bin);
  endfunction

  function automatic logic [1:0] ref1(input logic a, input logic b, input logic bin);
    return {1'b0, a} - {1'b0, b} - 2'(bin);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits for done8 from the negedge after a start edge; n = edges after start edge.
  task automatic wait_done8(output int n);
    n = 0;
    while (n < 64) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done8) break;
    end
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (n < 64) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done1) break;
    end
  endtask

  // One 8-bit operation, entered and left at a negedge in IDLE.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n;
    logic [8:0] r;
    r = ref8(a, b, bin);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    wait_done8(n);
    chk({tag, "_lat"}, 32'(n + 1), 32'd9);
    chk({tag, "_diff"}, 32'(diff8), 32'(r[7:0]));
    chk({tag, "_bout"}, 32'(bout8), 32'(r[8]));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
    chk({tag, "_idle"}, 32'(busy8), 32'd0);
  endtask

  task automatic op1(input string tag, input logic a, input logic b, input logic bin);
    int n;
    logic [1:0] r;
    r = ref1(a, b, bin);
    a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    wait_done1(n);
    chk({tag, "_lat"}, 32'(n + 1), 32'd2);
    chk({tag, "_diff"}, 32'(diff1), 32'(r[0]));
    chk({tag, "_bout"}, 32'(bout1), 32'(r[1]));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int dc0;
    logic [7:0] ra, rb;
    logic rbin;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;

    // Reset state
    #3;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed 8-bit cases
    op8("d05_03", 8'h05, 8'h03, 1'b0);
    op8("d00_01", 8'h00, 8'h01, 1'b0);
    op8("dff_ff", 8'hFF, 8'hFF, 1'b1);
    op8("d80_7f", 8'h80, 8'h7F, 1'b1);

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1($sformatf("w1_%0d", i), v[2], v[1], v[0]);
    end

    // Start held high with changing operands during RUN and DONE
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (done8) break;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      @(posedge clk); n++;
    end
    chk("hold_lat", 32'(n + 1), 32'd9);
    chk("hold_diff", 32'(diff8), 32'h02);
    chk("hold_bout", 32'(bout8), 32'd0);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hold_no_restart", 32'(busy8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    chk("hold_accept", 32'(busy8), 32'd1);
    wait_done8(n);
    chk("hold2_diff", 32'(diff8), 32'h0F);
    chk("hold2_bout", 32'(bout8), 32'd0);
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset mid-RUN
    a8 = 8'h30; b8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_done", 32'(done8), 32'd0);
    chk("arst_diff", 32'(diff8), 32'd0);
    chk("arst_bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op8("post_rst", 8'h30, 8'h10, 1'b0);

    // Back-to-back random operations
    dc0 = done_cnt8;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      op8($sformatf("rnd%0d", i), ra, rb, rbin);
    end
    chk("done_count", 32'(done_cnt8 - dc0), 32'd100);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor: the inverse datapath of our ripple full-adder cell, built from a single full-subtractor stage and a registered borrow. It accepts A, B and borrow-in on a start strobe, then processes one bit per clock, LSB first. It returns DIFF = A - B - bin and borrow-out with a one-cycle done pulse. It sits beside the adder blocks as the area-minimal arithmetic option for multi-cycle datapaths.

Parameters:
WIDTH, 8, operand and result width in bits (>=1).

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only when busy=0
a      input   WIDTH  minuend, sampled with accepted start
b      input   WIDTH  subtrahend, sampled with accepted start
bin    input   1      borrow-in, sampled with accepted start
busy   output  1      high in RUN and DONE states
done   output  1      one-cycle pulse; diff/bout valid from this cycle
diff   output  WIDTH  registered difference; held until next completion
bout   output  1      registered borrow-out; held until next completion

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset, asserted at any time including mid-operation, forces the following:
  - state=IDLE, busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and counter all go to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge loads a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, d_sh<=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - Bit logic: d = a_sh[0]^b_sh[0]^brw; nb = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&brw).
  - Shifts: d_sh <= {d, d_sh[WIDTH-1:1]}; a_sh and b_sh shift right by one; brw<=nb; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: diff<={d, d_sh[WIDTH-1:1]}, bout<=nb, next state DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k; done is high in the cycle following edge k+WIDTH (WIDTH+1 cycles after start). Throughput is one op per WIDTH+2 cycles.
- start while busy=1, including during DONE, is ignored. Input changes while busy have no effect.
- diff/bout change only on the completing edge; they are stable from done until the next completion.
- Arithmetic is modulo 2^WIDTH. bout=1 iff A < B+bin (unsigned).
- cnt width is clog2(WIDTH)+1. WIDTH=1 must work: RUN lasts one cycle.
- busy and done are decoded from registered state (glitch-free, no combinational path from inputs).

Decomposition:
- Shared package arith_pkg holds:
  - The state enum (IDLE/RUN/DONE) and its encoding constants.
  - A default-width constant shared with the adder blocks.
- One natural sub-module, full_subtractor, a combinational cell:
  - Inputs a, b, bin; outputs diff, bout.
  - It mirrors the existing full-adder cell and is instantiated once in the RUN datapath.

Test Plan:
- WIDTH=8, a=8'h05, b=8'h03, bin=0, start one cycle -> busy rises next cycle; done pulses exactly 9 cycles after start; diff=8'h02, bout=0.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1. Then a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0.
- WIDTH=1 exhaustive: all 8 combinations of a, b, bin at 10-time-unit spacing -> diff=a^b^bin, bout=(~a&b)|(~(a^b)&bin); done 2 cycles after each start.
- Start pulse held high during RUN and DONE with a changing operand -> no restart; result matches the first operands; next start accepted only after busy=0.
- rst_n driven low asynchronously mid-RUN (cnt=4) -> busy, done, diff, bout go to 0 immediately without a clock edge; a new op after release completes correctly.
- Back-to-back: start asserted in the first IDLE cycle after done, for 100 random operand pairs -> each diff/bout matches the reference model; done count equals accepted starts.
